// File: rtl/semiauto_nav.sv
// semiauto_nav: semi-automatic navigation controller.
//
// The car drives forward until a debounced crossroad is seen. It then waits for an operator
// command: straight, left, right or U-turn. Turn and cool-down phases are timed in external
// 20 ms ticks.
//
// Optional feature: define SEMIAUTO_NAV_QUEUE_EN to add a QDEPTH-entry command FIFO. Commands
// are then accepted in any enabled state and popped in WAIT. Without the FIFO, a command is
// accepted only while waiting.
//
// Ports:
//   sys_clk, rst          system clock, asynchronous active-low reset
//   tick                  one-cycle pulse every 20 ms
//   power, global_state   block enabled when power=1 and global_state is 01 or 10
//   detector[3:0]         line sensors; crossroad = d[0] | ~d[1] | ~d[2]
//   straight/back/left/right  level operator buttons (already debounced)
//   state[1:0]            FWD=01 WAIT=00 TURN=10 COOL=11
//   moving_state[3:0]     MOVE=0001 STOP=0000 TURN_LEFT=0100 TURN_RIGHT=1000
//   q_level               queued command count (0 without the FIFO)
//   cmd_drop              one-cycle pulse when a command is discarded
module semiauto_nav #(
  parameter int unsigned TURN_TICKS   = 100,
  parameter int unsigned AROUND_TICKS = 200,
  parameter int unsigned COOL_TICKS   = 50,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned QDEPTH       = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      power,
  input  logic [1:0]                global_state,
  input  logic [3:0]                detector,
  input  logic                      straight,
  input  logic                      back,
  input  logic                      left,
  input  logic                      right,
  output logic [1:0]                state,
  output logic [3:0]                moving_state,
  output logic [$clog2(QDEPTH):0]   q_level,
  output logic                      cmd_drop
);

  localparam logic [1:0] StFwd  = 2'b01;
  localparam logic [1:0] StWait = 2'b00;
  localparam logic [1:0] StTurn = 2'b10;
  localparam logic [1:0] StCool = 2'b11;

  localparam logic [3:0] MvMove  = 4'b0001;
  localparam logic [3:0] MvStop  = 4'b0000;
  localparam logic [3:0] MvLeft  = 4'b0100;
  localparam logic [3:0] MvRight = 4'b1000;

  localparam logic [1:0] CmdFwd    = 2'd0;
  localparam logic [1:0] CmdLeft   = 2'd1;
  localparam logic [1:0] CmdRight  = 2'd2;
  localparam logic [1:0] CmdAround = 2'd3;

  localparam logic [CNT_W-1:0] TurnLim   = CNT_W'(TURN_TICKS);
  localparam logic [CNT_W-1:0] AroundLim = CNT_W'(AROUND_TICKS);
  localparam logic [CNT_W-1:0] CoolLim   = CNT_W'(COOL_TICKS);

  localparam int unsigned DbW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);

  logic enabled;
  assign enabled = power & ((global_state == 2'b01) | (global_state == 2'b10));

  // Crossroad debounce: the flag flips only after raw has differed from it for DEBOUNCE cycles.
  logic           raw_cross, cross_q;
  logic [DbW-1:0] db_cnt_q;
  assign raw_cross = detector[0] | ~detector[1] | ~detector[2];

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cross_q  <= 1'b0;
      db_cnt_q <= '0;
    end else if (raw_cross == cross_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DbLast) begin
      cross_q  <= raw_cross;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  // Button rising edges, decoded into a registered one-cycle command.
  logic [3:0] btn, btn_q, rise;
  logic       dec_vld, cmd_vld_q;
  logic [1:0] dec_cmd, cmd_q;
  assign btn  = {straight, back, left, right};
  assign rise = btn & ~btn_q;

  always_comb begin
    dec_vld = 1'b1;
    dec_cmd = CmdFwd;
    if (rise[3])                  dec_cmd = CmdFwd;
    else if (rise[2])             dec_cmd = CmdAround;
    else if (rise[1] && !rise[0]) dec_cmd = CmdLeft;
    else if (rise[0] && !rise[1]) dec_cmd = CmdRight;
    else                          dec_vld = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      btn_q     <= '0;
      cmd_vld_q <= 1'b0;
      cmd_q     <= CmdFwd;
    end else begin
      btn_q     <= btn;
      cmd_vld_q <= dec_vld;
      cmd_q     <= dec_cmd;
    end
  end

  logic [1:0] state_q, state_d;
  logic [3:0] mv_q, mv_d;
  logic       have_cmd, drop;
  logic [1:0] head_cmd;

`ifdef SEMIAUTO_NAV_QUEUE_EN
  localparam int unsigned QW = $clog2(QDEPTH);
  localparam logic [QW:0] QFull = (QW+1)'(QDEPTH);

  logic [1:0]    q_mem [QDEPTH];
  logic [QW-1:0] wr_ptr_q, rd_ptr_q;
  logic [QW:0]   q_cnt_q;
  logic          push, pop, full, push_ok;

  assign push     = enabled & cmd_vld_q;
  assign pop      = enabled & (state_q == StWait) & (q_cnt_q != '0);
  assign full     = (q_cnt_q == QFull);
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign push_ok  = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign have_cmd = pop;
  assign head_cmd = q_mem[rd_ptr_q];
  assign q_level  = q_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (push_ok) q_mem[wr_ptr_q] <= cmd_q;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else if (!enabled) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   q_cnt_q <= q_cnt_q + 1'b1;
        2'b01:   q_cnt_q <= q_cnt_q - 1'b1;
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end
`else
  assign have_cmd = enabled & cmd_vld_q & (state_q == StWait);
  assign drop     = enabled & cmd_vld_q & (state_q != StWait);
  assign head_cmd = cmd_q;
  assign q_level  = '0;
`endif

  // Main sequencer.
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             around_q, around_d;
  assign cnt_inc = (tick && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    cnt_d    = cnt_q;
    around_d = around_q;
    if (!enabled) begin
      state_d  = StWait;
      mv_d     = MvStop;
      cnt_d    = '0;
      around_d = 1'b0;
    end else begin
      case (state_q)
        StFwd: begin
          mv_d = MvMove;
          if (cross_q) begin
            state_d = StWait;
            mv_d    = MvStop;
          end
        end
        StWait: begin
          mv_d = MvStop;
          if (have_cmd) begin
            cnt_d = '0;
            unique case (head_cmd)
              CmdFwd:    begin state_d = StCool; mv_d = MvMove;  end
              CmdLeft:   begin state_d = StTurn; mv_d = MvLeft;  end
              CmdRight:  begin state_d = StTurn; mv_d = MvRight; end
              CmdAround: begin state_d = StTurn; mv_d = MvLeft; around_d = 1'b1; end
              default:   ;
            endcase
          end
        end
        StTurn: begin
          if (cnt_q >= (around_q ? AroundLim : TurnLim)) begin
            state_d  = StCool;
            mv_d     = MvMove;
            cnt_d    = '0;
            around_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StCool: begin
          if (cnt_q >= CoolLim) begin
            state_d = StFwd;
            mv_d    = MvMove;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StWait;
          mv_d    = MvStop;
        end
      endcase
    end
  end

  logic drop_q;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StWait;
      mv_q     <= MvStop;
      cnt_q    <= '0;
      around_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mv_q     <= mv_d;
      cnt_q    <= cnt_d;
      around_q <= around_d;
      drop_q   <= drop;
    end
  end

  assign state        = state_q;
  assign moving_state = mv_q;
  assign cmd_drop     = drop_q;

endmodule

// File: tb/tb_semiauto_nav.sv
// Self-checking bench for semiauto_nav with default parameters. Each vector drives one cycle
// of inputs and queues the outputs expected after the following clock edge.
module tb_semiauto_nav;

  localparam logic [1:0] W = 2'b00, F = 2'b01, T = 2'b10, C = 2'b11;
  localparam logic [3:0] MV = 4'b0001, SP = 4'b0000, TL = 4'b0100, TR = 4'b1000;
  localparam logic [3:0] IDLE = 4'b0110, XRD = 4'b0001;

  logic       sys_clk = 1'b0;
  logic       rst, tick, power, straight, back, left, right;
  logic [1:0] global_state;
  logic [3:0] detector;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic [2:0] q_level;
  logic       cmd_drop;

  semiauto_nav dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .tick         (tick),
    .power        (power),
    .global_state (global_state),
    .detector     (detector),
    .straight     (straight),
    .back         (back),
    .left         (left),
    .right        (right),
    .state        (state),
    .moving_state (moving_state),
    .q_level      (q_level),
    .cmd_drop     (cmd_drop)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       pwr;
    logic [1:0] gs;
    logic [3:0] det;
    logic [3:0] btn;   // {straight, back, left, right}
    logic       tk;
    logic [1:0] st;
    logic [3:0] mv;
    logic       drop;
    logic [2:0] ql;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic       cur_pwr;
  logic [1:0] cur_gs;
  logic [3:0] cur_det, cur_btn;

  function automatic vec_t mk(logic pwr, logic [1:0] gs, logic [3:0] det, logic [3:0] btn,
                              logic tk, logic [1:0] st, logic [3:0] mv, logic drop,
                              logic [2:0] ql);
    vec_t v;
    v.pwr = pwr; v.gs = gs; v.det = det; v.btn = btn; v.tk = tk;
    v.st = st; v.mv = mv; v.drop = drop; v.ql = ql;
    return v;
  endfunction

  task automatic check(input vec_t e, input string name);
    n_vec++;
    if (state !== e.st || moving_state !== e.mv || cmd_drop !== e.drop || q_level !== e.ql) begin
      n_bad++;
      $display("FAIL %s #%0d @%0t: got state=%b moving=%b drop=%b q_level=%0d, want state=%b moving=%b drop=%b q_level=%0d",
               name, n_vec, $time, state, moving_state, cmd_drop, q_level,
               e.st, e.mv, e.drop, e.ql);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    cur_pwr = v.pwr; cur_gs = v.gs; cur_det = v.det; cur_btn = v.btn;
    power = v.pwr; global_state = v.gs; detector = v.det; tick = v.tk;
    {straight, back, left, right} = v.btn;
    sb.push_back(v);
    @(posedge sys_clk);
    #1;
    e = sb.pop_front();
    check(e, name);
  endtask

  // One cycle with the current inputs.
  task automatic hold(input logic tk, input logic [1:0] st, input logic [3:0] mv,
                      input logic drop, input logic [2:0] ql, input string name);
    apply(mk(cur_pwr, cur_gs, cur_det, cur_btn, tk, st, mv, drop, ql), name);
  endtask

  // n tick pulses separated by gap idle cycles; the state must hold throughout.
  task automatic dwell(input int n, input int gap, input logic [1:0] st, input logic [3:0] mv,
                       input logic [2:0] ql, input string name);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, st, mv, 1'b0, ql, name);
      if (i < n - 1) repeat (gap) hold(1'b0, st, mv, 1'b0, ql, name);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], name);
    tbl.delete();
  endtask

  // Crossroad from FWD: WAIT is reached on the 5th edge of raw assertion.
  task automatic xroad(input logic [2:0] ql);
    cur_det = XRD;
    repeat (4) hold(1'b0, F, MV, 1'b0, ql, "xroad_fwd");
    hold(1'b0, W, SP, 1'b0, ql, "xroad_wait");
  endtask

  task automatic async_reset(input string name);
    #1 rst = 1'b0;
    #2 check(mk(1'b1, 2'b01, IDLE, 4'b0, 1'b0, W, SP, 1'b0, 3'd0), name);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; power = 1'b1; global_state = 2'b01; detector = IDLE; tick = 1'b0;
    {straight, back, left, right} = 4'b0;
    cur_pwr = 1'b1; cur_gs = 2'b01; cur_det = IDLE; cur_btn = 4'b0;
    #7 check(mk(1'b1, 2'b01, IDLE, 4'b0, 1'b0, W, SP, 1'b0, 3'd0), "reset");
    rst = 1'b1;

`ifndef SEMIAUTO_NAV_QUEUE_EN
    // Straight in WAIT: decoded on edge 1, dispatched to COOL on edge 2.
    apply(mk(1, 2'b01, IDLE, 4'b1000, 0, W, SP, 0, 0), "straight_decode");
    apply(mk(1, 2'b01, IDLE, 4'b1000, 0, C, MV, 0, 0), "straight_dispatch");
    cur_btn = 4'b0;
    dwell(50, 1, C, MV, 0, "cool_dwell");
    hold(1'b0, F, MV, 1'b0, 0, "cool_exit");

    // Debounce, then back (U-turn) and simultaneous left+right in WAIT.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 2'b01, XRD, 4'b0, 0, F, MV, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 2'b01, IDLE, 4'b0, 0, F, MV, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 2'b01, XRD, 4'b0, 0, F, MV, 0, 0));
    tbl.push_back(mk(1, 2'b01, XRD,  4'b0000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0011, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0011, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0100, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0100, 0, T, TL, 0, 0));
    run_table("debounce_cmds");

    cur_btn = 4'b0;
    dwell(200, 1, T, TL, 0, "around_dwell");
    hold(1'b0, C, MV, 1'b0, 0, "around_exit");
    dwell(50, 0, C, MV, 0, "cool2_dwell");
    hold(1'b1, F, MV, 1'b0, 0, "cool2_exit");

    // Command outside WAIT is dropped; then a right turn from a crossroad.
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0010, 0, F, MV, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 1, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 2'b01, XRD, 4'b0, 0, F, MV, 0, 0));
    tbl.push_back(mk(1, 2'b01, XRD,  4'b0000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0001, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0001, 0, T, TR, 0, 0));
    run_table("drop_right");

    // Power loss mid-turn aborts to WAIT; then a full right turn exits at 100 ticks.
    cur_btn = 4'b0;
    dwell(10, 0, T, TR, 0, "turn_pre_pwr");
    cur_pwr = 1'b0;
    hold(1'b0, W, SP, 1'b0, 0, "pwr_drop");
    cur_pwr = 1'b1;
    hold(1'b0, W, SP, 1'b0, 0, "pwr_back");
    apply(mk(1, 2'b01, IDLE, 4'b0001, 0, W, SP, 0, 0), "right_decode");
    apply(mk(1, 2'b01, IDLE, 4'b0001, 0, T, TR, 0, 0), "right_dispatch");
    cur_btn = 4'b0;
    dwell(100, 0, T, TR, 0, "turn_dwell");
    hold(1'b0, C, MV, 1'b0, 0, "turn_exit");
    dwell(20, 0, C, MV, 0, "cool3_dwell");
    async_reset("async_reset_cool");

    // Edge history keeps updating while disabled: a held button is not a new edge.
    tbl.push_back(mk(1, 2'b11, IDLE, 4'b1000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b11, IDLE, 4'b1000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b10, IDLE, 4'b1000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b10, IDLE, 4'b1000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b10, IDLE, 4'b0000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b10, IDLE, 4'b1000, 0, W, SP, 0, 0));
    tbl.push_back(mk(1, 2'b10, IDLE, 4'b1000, 0, C, MV, 0, 0));
    run_table("disabled");
`else
    // Queued straight: decode, push, then pop/dispatch.
    apply(mk(1, 2'b01, IDLE, 4'b1000, 0, W, SP, 0, 0), "q_straight_decode");
    apply(mk(1, 2'b01, IDLE, 4'b0000, 0, W, SP, 0, 1), "q_straight_push");
    apply(mk(1, 2'b01, IDLE, 4'b0000, 0, C, MV, 0, 0), "q_straight_pop");
    dwell(50, 1, C, MV, 0, "q_cool_dwell");
    hold(1'b0, F, MV, 1'b0, 0, "q_cool_exit");

    // Push L, R, F, B, L while driving; the fifth overflows.
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0010, 0, F, MV, 0, 0));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 0, 1));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0001, 0, F, MV, 0, 1));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 0, 2));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b1000, 0, F, MV, 0, 2));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 0, 3));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0100, 0, F, MV, 0, 3));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 0, 4));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0010, 0, F, MV, 0, 4));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 1, 4));
    tbl.push_back(mk(1, 2'b01, IDLE, 4'b0000, 0, F, MV, 0, 4));
    run_table("q_fill");

    xroad(4);
    cur_det = IDLE;
    hold(1'b0, T, TL, 1'b0, 3, "q_pop_left");
    dwell(100, 0, T, TL, 3, "q_left_dwell");
    hold(1'b0, C, MV, 1'b0, 3, "q_left_exit");
    dwell(50, 0, C, MV, 3, "q_cool_l");
    hold(1'b0, F, MV, 1'b0, 3, "q_fwd_l");

    xroad(3);
    cur_det = IDLE;
    hold(1'b0, T, TR, 1'b0, 2, "q_pop_right");
    dwell(100, 0, T, TR, 2, "q_right_dwell");
    hold(1'b0, C, MV, 1'b0, 2, "q_right_exit");
    dwell(50, 0, C, MV, 2, "q_cool_r");
    hold(1'b0, F, MV, 1'b0, 2, "q_fwd_r");

    xroad(2);
    cur_det = IDLE;
    hold(1'b0, C, MV, 1'b0, 1, "q_pop_fwd");
    dwell(10, 0, C, MV, 1, "q_cool_f");
    cur_pwr = 1'b0;
    hold(1'b0, W, SP, 1'b0, 0, "q_pwr_flush");
    cur_pwr = 1'b1;
    hold(1'b0, W, SP, 1'b0, 0, "q_pwr_back");
    hold(1'b0, W, SP, 1'b0, 0, "q_empty_wait");
    async_reset("q_async_reset");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
